ffn_silu_ctrl: RTL and testbench

SiLU activation sequencer for the FFN path, directly upstream of the FFN element-wise multiply stage. It computes silu(x) = x · 1/(1+exp(−x)) on VALUE_MN lanes by time-multiplexing the shared FMA array through four ops: EXP, ADD, RECIP, MUL. It holds each intermediate result in an internal vector register. Its `silu_out` / `silu_out_valid` feed the multiply stage's `silu_in` / `start_ffn_mul`.

---
 rtl/ffn_silu_ctrl_pkg.sv | 28 ++
 rtl/ffn_silu_ctrl_lane_negate.sv | 16 +
 rtl/ffn_silu_ctrl.sv | 140 ++++++++++++++
 tb/tb_ffn_silu_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ffn_silu_ctrl_pkg.sv
// Shared definitions for the FFN SiLU sequencer: FMA mode codes, the 1.0 lane constant, FSM states.
package ffn_pkg;

  localparam int FP_EXP = 8;
  localparam int FP_MAN = 9;
  localparam int FP_W   = 17;

  localparam logic [4:0] FMA_MODE_ADD = 5'b00001;
  localparam logic [4:0] FMA_MODE_MUL = 5'b00010;
  localparam logic [4:0] FMA_MODE_EXP = 5'b00100;
  localparam logic [4:0] FMA_MODE_RCP = 5'b01000;

  // Mantissa width counts the hidden bit, so the stored fraction is bw_man-1 bits.
  function automatic int one_fp_bits(input int bw_exp, input int bw_man);
    return ((1 << (bw_exp - 1)) - 1) << (bw_man - 1);
  endfunction

  localparam logic [FP_W-1:0] ONE_FP = FP_W'(one_fp_bits(FP_EXP, FP_MAN));

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_ADD,
    S_RCP,
    S_MUL
  } silu_state_t;

endpackage

// File: rtl/ffn_silu_ctrl_lane_negate.sv
// Per-lane sign flip of a packed lane vector; purely combinational, no flow control.
module ffn_lane_negate
  import ffn_pkg::*;
#(
  parameter int BW_FP    = FP_W,
  parameter int VALUE_MN = 64
) (
  input  logic [VALUE_MN*BW_FP-1:0] x,
  output logic [VALUE_MN*BW_FP-1:0] x_neg
);

  for (genvar i = 0; i < VALUE_MN; i++) begin : g_lane
    assign x_neg[i*BW_FP +: BW_FP] = {~x[i*BW_FP + BW_FP - 1], x[i*BW_FP +: BW_FP-1]};
  end

endmodule

// File: rtl/ffn_silu_ctrl.sv
// SiLU sequencer over a shared FMA array (EXP, ADD, RCP, MUL); result 4*(FMA_LAT+1) cycles after start.
// Starts while busy are dropped; FFN_SILU_INLATCH_EN adds an input register for gate_proj.
module ffn_silu_ctrl
  import ffn_pkg::*;
#(
  parameter int BW_EXP   = FP_EXP,
  parameter int BW_MAN   = FP_MAN,
  parameter int BW_FP    = FP_W,
  parameter int VALUE_MN = 64,
  parameter int FMA_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_ffn_silu,
  input  logic [VALUE_MN*BW_FP-1:0] gate_proj,
  input  logic [VALUE_MN*BW_FP-1:0] FMA_out,
  output logic                      busy_ffn_silu,
  output logic [VALUE_MN*5-1:0]     mode_ffn_silu,
  output logic [VALUE_MN*BW_FP-1:0] a_ffn_silu,
  output logic [VALUE_MN*BW_FP-1:0] b_ffn_silu,
  output logic [VALUE_MN*BW_FP-1:0] silu_out,
  output logic                      silu_out_valid
);

  localparam int                VW       = VALUE_MN * BW_FP;
  localparam int                PH_W     = (FMA_LAT < 1) ? 1 : $clog2(FMA_LAT + 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(FMA_LAT);
  localparam logic [BW_FP-1:0]  ONE_LANE = BW_FP'(one_fp_bits(BW_EXP, BW_MAN));

  silu_state_t     state, state_nxt;
  logic [PH_W-1:0] ph;
  logic [VW-1:0]   tmp;
  logic [VW-1:0]   x_cur;
  logic [VW-1:0]   x_neg;
  logic [4:0]      mode_lane;
  logic            start_ok;
  logic            issue;
  logic            capture;

  assign start_ok      = (state == S_IDLE) && start_ffn_silu;
  assign issue         = (state != S_IDLE) && (ph == '0);
  assign capture       = (state != S_IDLE) && (ph == PH_LAST);
  assign busy_ffn_silu = (state != S_IDLE);

`ifdef FFN_SILU_INLATCH_EN
  logic [VW-1:0] x_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
    end else if (start_ok) begin
      x_reg <= gate_proj;
    end
  end

  assign x_cur = x_reg;
`else
  assign x_cur = gate_proj;
`endif

  ffn_lane_negate #(
    .BW_FP    (BW_FP),
    .VALUE_MN (VALUE_MN)
  ) u_negate (
    .x     (x_cur),
    .x_neg (x_neg)
  );

  always_comb begin
    state_nxt  = state;
    mode_lane  = '0;
    a_ffn_silu = '0;
    b_ffn_silu = '0;
    case (state)
      S_IDLE: begin
        if (start_ffn_silu) state_nxt = S_EXP;
      end
      S_EXP: begin
        if (issue) begin
          mode_lane  = FMA_MODE_EXP;
          a_ffn_silu = x_neg;
        end
        if (capture) state_nxt = S_ADD;
      end
      S_ADD: begin
        if (issue) begin
          mode_lane  = FMA_MODE_ADD;
          a_ffn_silu = tmp;
          b_ffn_silu = {VALUE_MN{ONE_LANE}};
        end
        if (capture) state_nxt = S_RCP;
      end
      S_RCP: begin
        if (issue) begin
          mode_lane  = FMA_MODE_RCP;
          a_ffn_silu = tmp;
        end
        if (capture) state_nxt = S_MUL;
      end
      S_MUL: begin
        if (issue) begin
          mode_lane  = FMA_MODE_MUL;
          a_ffn_silu = x_cur;
          b_ffn_silu = tmp;
        end
        if (capture) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    mode_ffn_silu = {VALUE_MN{mode_lane}};
  end

  // The final capture lands in silu_out instead of tmp and is flagged by a one-cycle valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ph             <= '0;
      tmp            <= '0;
      silu_out       <= '0;
      silu_out_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      silu_out_valid <= 1'b0;
      if (state == S_IDLE || capture) begin
        ph <= '0;
      end else begin
        ph <= ph + 1'b1;
      end
      if (capture) begin
        if (state == S_MUL) begin
          silu_out       <= FMA_out;
          silu_out_valid <= 1'b1;
        end else begin
          tmp <= FMA_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_ffn_silu_ctrl.sv
// Directed bench for ffn_silu_ctrl with a two-stage FMA stand-in and hand-derived expectations.
module tb_ffn_silu_ctrl;

  localparam int VALUE_MN = 64;
  localparam int BW_FP    = 17;
  localparam int VW       = VALUE_MN * BW_FP;
  localparam logic [16:0] ONE_LANE = 17'h07F00;
  localparam logic [4:0]  M_ADD = 5'b00001;
  localparam logic [4:0]  M_MUL = 5'b00010;
  localparam logic [4:0]  M_EXP = 5'b00100;
  localparam logic [4:0]  M_RCP = 5'b01000;

  typedef logic [VW-1:0] vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_ffn_silu;
  vec_t                  gate_proj;
  vec_t                  FMA_out;
  logic                  busy_ffn_silu;
  logic [VALUE_MN*5-1:0] mode_ffn_silu;
  vec_t                  a_ffn_silu;
  vec_t                  b_ffn_silu;
  vec_t                  silu_out;
  logic                  silu_out_valid;

  int n_chk = 0;
  int n_bad = 0;

  vec_t fma_p1 = '0;
  vec_t fma_p2 = '0;

  always #5 clk = ~clk;

  ffn_silu_ctrl #(
    .BW_EXP   (8),
    .BW_MAN   (9),
    .BW_FP    (BW_FP),
    .VALUE_MN (VALUE_MN),
    .FMA_LAT  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_ffn_silu (start_ffn_silu),
    .gate_proj      (gate_proj),
    .FMA_out        (FMA_out),
    .busy_ffn_silu  (busy_ffn_silu),
    .mode_ffn_silu  (mode_ffn_silu),
    .a_ffn_silu     (a_ffn_silu),
    .b_ffn_silu     (b_ffn_silu),
    .silu_out       (silu_out),
    .silu_out_valid (silu_out_valid)
  );

  // Arbitrary but distinct per-op lane functions stand in for the real FMA arithmetic.
  function automatic logic [16:0] lane_op(input logic [4:0] m, input logic [16:0] a, input logic [16:0] b);
    case (m)
      M_ADD:   return a + b;
      M_MUL:   return a ^ {b[7:0], b[16:8]};
      M_EXP:   return a + 17'h00321;
      M_RCP:   return ~a;
      default: return 17'h0;
    endcase
  endfunction

  function automatic vec_t vec_op(input logic [VALUE_MN*5-1:0] m, input vec_t a, input vec_t b);
    vec_t r;
    for (int i = 0; i < VALUE_MN; i++)
      r[i*BW_FP +: BW_FP] = lane_op(m[i*5 +: 5], a[i*BW_FP +: BW_FP], b[i*BW_FP +: BW_FP]);
    return r;
  endfunction

  always @(posedge clk) begin
    fma_p1 <= vec_op(mode_ffn_silu, a_ffn_silu, b_ffn_silu);
    fma_p2 <= fma_p1;
  end
  assign FMA_out = fma_p2;

  function automatic vec_t negate(input vec_t x);
    vec_t r = x;
    for (int i = 0; i < VALUE_MN; i++) r[i*BW_FP + 16] = ~x[i*BW_FP + 16];
    return r;
  endfunction

  function automatic vec_t make_pat(input int k);
    vec_t r;
    for (int i = 0; i < VALUE_MN; i++) r[i*BW_FP +: BW_FP] = 17'(i * k * 37 + k * 911 + (i % 3) * 65536);
    return r;
  endfunction

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    int lane;
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      lane = 0;
      for (int i = VALUE_MN - 1; i >= 0; i--)
        if (got[i*BW_FP +: BW_FP] !== exp[i*BW_FP +: BW_FP]) lane = i;
      $display("FAIL %s lane%0d got=%h exp=%h", tag, lane,
               got[lane*BW_FP +: BW_FP], exp[lane*BW_FP +: BW_FP]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input vec_t x, input int dup_start_at);
    vec_t ones, e, s, r, y;
    ones = {VALUE_MN{ONE_LANE}};
    e = vec_op({VALUE_MN{M_EXP}}, negate(x), '0);
    s = vec_op({VALUE_MN{M_ADD}}, e, ones);
    r = vec_op({VALUE_MN{M_RCP}}, s, '0);
    y = vec_op({VALUE_MN{M_MUL}}, x, r);
    gate_proj      = x;
    start_ffn_silu = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      start_ffn_silu = (c == dup_start_at);
`ifdef FFN_SILU_INLATCH_EN
      if (c == 1) gate_proj = ~x;
`endif
      chk($sformatf("c%0d busy", c), vec_t'(busy_ffn_silu), vec_t'(1'b1));
      chk($sformatf("c%0d valid", c), vec_t'(silu_out_valid), vec_t'(1'b0));
      case (c)
        0: begin
          chk("exp mode", vec_t'(mode_ffn_silu), vec_t'({VALUE_MN{M_EXP}}));
          chk("exp a", a_ffn_silu, negate(x));
          chk("exp b", b_ffn_silu, '0);
        end
        3: begin
          chk("add mode", vec_t'(mode_ffn_silu), vec_t'({VALUE_MN{M_ADD}}));
          chk("add a", a_ffn_silu, e);
          chk("add b", b_ffn_silu, ones);
        end
        6: begin
          chk("rcp mode", vec_t'(mode_ffn_silu), vec_t'({VALUE_MN{M_RCP}}));
          chk("rcp a", a_ffn_silu, s);
          chk("rcp b", b_ffn_silu, '0);
        end
        9: begin
          chk("mul mode", vec_t'(mode_ffn_silu), vec_t'({VALUE_MN{M_MUL}}));
          chk("mul a", a_ffn_silu, x);
          chk("mul b", b_ffn_silu, r);
        end
        default: begin
          chk($sformatf("c%0d mode idle", c), vec_t'(mode_ffn_silu), '0);
          chk($sformatf("c%0d a idle", c), a_ffn_silu, '0);
          chk($sformatf("c%0d b idle", c), b_ffn_silu, '0);
        end
      endcase
      step();
    end
    start_ffn_silu = 1'b0;
    gate_proj      = x;
    chk("done valid", vec_t'(silu_out_valid), vec_t'(1'b1));
    chk("done result", silu_out, y);
    chk("done busy", vec_t'(busy_ffn_silu), vec_t'(1'b0));
  endtask

  initial begin
    vec_t y_hold;
    rst            = 1'b1;
    start_ffn_silu = 1'b0;
    gate_proj      = '0;
    repeat (3) step();
    chk("rst busy", vec_t'(busy_ffn_silu), vec_t'(1'b0));
    chk("rst valid", vec_t'(silu_out_valid), vec_t'(1'b0));
    chk("rst silu_out", silu_out, '0);
    chk("rst mode", vec_t'(mode_ffn_silu), '0);
    chk("rst a", a_ffn_silu, '0);
    chk("rst b", b_ffn_silu, '0);
    rst = 1'b0;
    step();
    chk("idle mode", vec_t'(mode_ffn_silu), '0);

    run_seq({VALUE_MN{ONE_LANE}}, -1);
    y_hold = silu_out;
    step();
    chk("post valid low", vec_t'(silu_out_valid), vec_t'(1'b0));
    repeat (3) step();
    chk("hold result", silu_out, y_hold);
    chk("idle a", a_ffn_silu, '0);

    // Duplicate start at E5 is dropped; the following run starts the cycle right after valid.
    run_seq(make_pat(3), 4);
    run_seq(make_pat(7), -1);
    step();

    gate_proj      = make_pat(11);
    start_ffn_silu = 1'b1;
    step();
    start_ffn_silu = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst busy", vec_t'(busy_ffn_silu), vec_t'(1'b0));
    chk("mid rst valid", vec_t'(silu_out_valid), vec_t'(1'b0));
    chk("mid rst silu_out", silu_out, '0);
    chk("mid rst mode", vec_t'(mode_ffn_silu), '0);
    chk("mid rst a", a_ffn_silu, '0);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("post rst valid c%0d", c), vec_t'(silu_out_valid), vec_t'(1'b0));
      step();
    end
    run_seq(make_pat(11), -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
